vga_bounce_renderer: RTL
========================

Name: vga_bounce_renderer

Overview:
- Pixel-colour stage directly downstream of the VGA 640x480 timing generator.
- Consumes the generator's pixel coordinates, active flag, frame tick and sync signals.
- Draws a solid box over a background colour. The box moves once per frame and bounces off the screen edges, changing colour on each bounce.
- Drives the 12-bit RGB pins and re-times hs/vs so colour and sync stay aligned.

Parameters:
H_VISIBLE, 640, visible pixels per line
V_VISIBLE, 480, visible lines per frame
BOX_W, 32, box width in pixels (must be > SPEED and < H_VISIBLE)
BOX_H, 32, box height in lines (must be > SPEED and < V_VISIBLE)
SPEED, 2, pixels moved per axis per frame tick (1..15)
BG_COLOR, 12'h003, background RGB {r[3:0],g[3:0],b[3:0]}

Ports:
clk  input  1  pixel clock
rst  input  1  synchronous reset, active-high
px_x  input  10  current pixel column from timing stage
px_y  input  10  current pixel line from timing stage
px_active  input  1  1 when (px_x,px_y) is in the visible area
frame_tick  input  1  one-cycle pulse, once per frame, during vertical blank
hs_in  input  1  horizontal sync from timing stage (active-low)
vs_in  input  1  vertical sync from timing stage (active-low)
pause  input  1  1 freezes box motion
rgb  output  12  {r3..r0,g3..g0,b3..b0} to the DAC pins
hs_out  output  1  hs_in delayed to match rgb
vs_out  output  1  vs_in delayed to match rgb
bounce  output  1  one-cycle pulse on any bounce
color_idx  output  3  current palette index

Behaviour:
- Reset (synchronous, rst=1) sets:
  - box_x=0, box_y=0
  - dir_x=+ (right), dir_y=+ (down)
  - color_idx=0, bounce=0, rgb=12'h000
  - hs_out=1, vs_out=1, all pipeline registers cleared (sync taps to 1)
- Reset mid-frame: outputs are forced to the reset values the cycle after rst is sampled. Normal output resumes 2 cycles after rst deasserts.
- Pipeline, fixed latency 2 cycles from px_*/hs_in/vs_in to rgb/hs_out/vs_out:
  - Stage 1 registers active_d = px_active.
  - Stage 1 registers inside = px_active && px_x>=box_x && px_x<box_x+BOX_W && px_y>=box_y && px_y<box_y+BOX_H. Compare at 11 bits, no wrap.
  - Stage 1 registers the hs/vs taps.
  - Stage 2 sets rgb = !active_d ? 12'h000 : inside ? PALETTE[color_idx] : BG_COLOR.
  - Stage 2 passes the hs/vs taps through to hs_out/vs_out.
- PALETTE[0..7]: F00, 0F0, 00F, FF0, 0FF, F0F, FFF, F80.
- Motion, evaluated only on a cycle with frame_tick=1 and pause=0. X and Y are updated independently in the same cycle.
  - X moving +: if box_x+SPEED >= H_VISIBLE-BOX_W then box_x = H_VISIBLE-BOX_W, dir_x flips to −, hit_x=1. Else box_x += SPEED.
  - X moving −: if box_x <= SPEED then box_x = 0, dir_x flips to +, hit_x=1. Else box_x −= SPEED.
  - Y: same rules with box_y, V_VISIBLE, BOX_H, dir_y, hit_y.
- Bounce handling:
  - If hit_x | hit_y: color_idx increments by exactly 1 (wraps 7→0) and bounce pulses high for the next cycle only.
  - A corner hit (both axes in the same tick) counts as a single bounce.
- frame_tick with pause=1: no position, direction or colour change, no bounce pulse.
- frame_tick with rst=1: reset wins.
- frame_tick must be 1 cycle wide. A tick held high for N cycles moves the box N times; this is legal and not guarded.
- The box position is read by stage 1 one cycle after update. frame_tick lies in vertical blank, so no tearing occurs.
- The block has no internal timing counters. It relies solely on the inputs and does not validate px_x/px_y ranges beyond px_active.

Test Plan:
- Reset then one line with px_y=0, px_active=1, px_x=0..40 -> rgb=F00 for x=0..31, BG 003 for x=32..40. Each value appears 2 cycles after its input; hs_out/vs_out equal hs_in/vs_in delayed 2.
- px_active=0 anywhere (including inside box coordinates) -> rgb=000 after 2 cycles.
- 224 frame_ticks from reset (SPEED=2) -> box_y=448, dir_y=−, color_idx=1, bounce pulsed once at tick 224, box_x=448.
- Continue to tick 304 -> box_x=608, dir_x=−, color_idx=2; exactly 2 bounce pulses total.
- Parameter set with BOX_W=BOX_H=32, H_VISIBLE=V_VISIBLE=64, SPEED=2: 16 ticks -> simultaneous X/Y hit, color_idx increments by 1 only, single bounce pulse.
- pause=1 over 10 ticks -> position and color_idx unchanged. Then assert rst mid-line -> rgb=000, hs_out=vs_out=1, box back at (0,0), color_idx=0.

Source files
------------

// File: rtl/vga_bounce_if.sv
// Pixel-stream bundle between the VGA timing stage and the bounce renderer.
// Latency: n/a (wires only).
// Backpressure: none; the pixel stream is free-running and never stalls.
// Ports:
//   timing -> renderer: px_x, px_y, px_active, frame_tick, hs_in, vs_in, pause
//   renderer -> pins  : rgb, hs_out, vs_out, bounce, color_idx
interface vga_bounce_if;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic        px_active;
    logic        frame_tick;
    logic        hs_in;
    logic        vs_in;
    logic        pause;
    logic [11:0] rgb;
    logic        hs_out;
    logic        vs_out;
    logic        bounce;
    logic [2:0]  color_idx;

    modport master (
        output px_x, px_y, px_active, frame_tick, hs_in, vs_in, pause,
        input  rgb, hs_out, vs_out, bounce, color_idx
    );

    modport slave (
        input  px_x, px_y, px_active, frame_tick, hs_in, vs_in, pause,
        output rgb, hs_out, vs_out, bounce, color_idx
    );
endinterface

// File: rtl/vga_bounce_renderer.sv
// Draws a bouncing solid box over a background colour on a VGA pixel stream.
// Latency: 2 cycles from px_*/hs_in/vs_in to rgb/hs_out/vs_out.
// Backpressure: none; one pixel in and one pixel out every clock.
// Ports: clk, rst (sync, active-high); bus (slave side of vga_bounce_if):
//   pixel coordinates/active/syncs in, 12-bit rgb plus re-timed syncs out,
//   bounce pulse and current palette index as status.
module vga_bounce_renderer #(
    parameter int          H_VISIBLE = 640,
    parameter int          V_VISIBLE = 480,
    parameter int          BOX_W     = 32,
    parameter int          BOX_H     = 32,
    parameter int          SPEED     = 2,
    parameter logic [11:0] BG_COLOR  = 12'h003
) (
    input  logic        clk,
    input  logic        rst,
    vga_bounce_if.slave bus
);
    localparam logic [10:0] X_MAX   = 11'(H_VISIBLE - BOX_W);
    localparam logic [10:0] Y_MAX   = 11'(V_VISIBLE - BOX_H);
    localparam logic [10:0] SPD     = 11'(SPEED);
    localparam logic [10:0] BOX_W11 = 11'(BOX_W);
    localparam logic [10:0] BOX_H11 = 11'(BOX_H);

    function automatic logic [11:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 12'hF00;
            3'd1:    palette = 12'h0F0;
            3'd2:    palette = 12'h00F;
            3'd3:    palette = 12'hFF0;
            3'd4:    palette = 12'h0FF;
            3'd5:    palette = 12'hF0F;
            3'd6:    palette = 12'hFFF;
            default: palette = 12'hF80;
        endcase
    endfunction

    // Box state; dir bit 1 means moving +x (right) / +y (down).
    logic [10:0] box_x_q, box_x_d, box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [2:0]  color_q, color_d;
    logic        bounce_q, bounce_d;
    logic        hit_x, hit_y;

    // Pixel pipeline.
    logic        active_q, inside_q, hs1_q, vs1_q;
    logic        inside_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs2_q, vs2_q;

    // Motion: both axes evaluated independently; a corner hit is one bounce.
    always_comb begin
        box_x_d  = box_x_q;
        box_y_d  = box_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        color_d  = color_q;
        bounce_d = 1'b0;
        hit_x    = 1'b0;
        hit_y    = 1'b0;
        if (bus.frame_tick && !bus.pause) begin
            if (dir_x_q) begin
                if (box_x_q + SPD >= X_MAX) begin
                    box_x_d = X_MAX;
                    dir_x_d = 1'b0;
                    hit_x   = 1'b1;
                end else begin
                    box_x_d = box_x_q + SPD;
                end
            end else begin
                if (box_x_q <= SPD) begin
                    box_x_d = '0;
                    dir_x_d = 1'b1;
                    hit_x   = 1'b1;
                end else begin
                    box_x_d = box_x_q - SPD;
                end
            end
            if (dir_y_q) begin
                if (box_y_q + SPD >= Y_MAX) begin
                    box_y_d = Y_MAX;
                    dir_y_d = 1'b0;
                    hit_y   = 1'b1;
                end else begin
                    box_y_d = box_y_q + SPD;
                end
            end else begin
                if (box_y_q <= SPD) begin
                    box_y_d = '0;
                    dir_y_d = 1'b1;
                    hit_y   = 1'b1;
                end else begin
                    box_y_d = box_y_q - SPD;
                end
            end
            if (hit_x || hit_y) begin
                color_d  = color_q + 3'd1;
                bounce_d = 1'b1;
            end
        end
    end

    // Compare at 11 bits so box_x+BOX_W cannot wrap at the right edge.
    always_comb begin
        inside_d = bus.px_active
                && ({1'b0, bus.px_x} >= box_x_q) && ({1'b0, bus.px_x} < box_x_q + BOX_W11)
                && ({1'b0, bus.px_y} >= box_y_q) && ({1'b0, bus.px_y} < box_y_q + BOX_H11);
    end

    always_comb begin
        rgb_d = 12'h000;
        if (active_q) begin
            rgb_d = inside_q ? palette(color_q) : BG_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            box_x_q  <= '0;
            box_y_q  <= '0;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            color_q  <= '0;
            bounce_q <= 1'b0;
            active_q <= 1'b0;
            inside_q <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            rgb_q    <= 12'h000;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
        end else begin
            box_x_q  <= box_x_d;
            box_y_q  <= box_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            color_q  <= color_d;
            bounce_q <= bounce_d;
            active_q <= bus.px_active;
            inside_q <= inside_d;
            hs1_q    <= bus.hs_in;
            vs1_q    <= bus.vs_in;
            rgb_q    <= rgb_d;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.hs_out    = hs2_q;
    assign bus.vs_out    = vs2_q;
    assign bus.bounce    = bounce_q;
    assign bus.color_idx = color_q;
endmodule
